mdu_sched: RTL and testbench



---
 rtl/mdu_sched_pkg.sv | 52 +++++
 rtl/mdu_sched_chk.sv | 22 ++
 rtl/mdu_sched_md_calc.sv | 69 ++++++
 rtl/mdu_sched.sv | 133 +++++++++++++
 tb/tb_mdu_sched.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/mdu_sched_pkg.sv
// Shared definitions for the multiply/divide scheduler.
// Holds the MD operation encoding seen on E_md_op, the RF write-data
// select code used when MFHI/MFLO write the register file, the result
// bundle produced by md_calc and small op-decode helper functions.
package mdu_sched_pkg;

    localparam int MD_OP_W = 4;

    typedef enum logic [MD_OP_W-1:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MFHI  = 4'd7,
        MD_MFLO  = 4'd8
    } md_op_e;

    // Select code for the E-stage RF write-data mux: take md_out.
    localparam logic [2:0] RF_WD_MD = 3'd4;

    // Full 64-bit result of one MULT/DIV. wr_en is low for a divide by
    // zero, in which case HI/LO must keep their old contents.
    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        wr_en;
    } md_res_t;

    // True for the ops that occupy the MDU for several cycles.
    function automatic logic is_muldiv(input logic [MD_OP_W-1:0] op);
        logic r;
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: r = 1'b1;
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

    // True for the multiply ops (selects the shorter latency).
    function automatic logic is_mult(input logic [MD_OP_W-1:0] op);
        logic r;
        case (op)
            MD_MULT, MD_MULTU: r = 1'b1;
            default:           r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mdu_sched_chk.sv
// Simulation checker for mdu_sched: flags MD ops that the hazard unit
// should never let reach E while the MDU is occupied.
// Ports: clk, reset, busy_i (MDU occupied), op_i (E-stage MD op).
module mdu_sched_chk
    import mdu_sched_pkg::*;
(
    input logic               clk,
    input logic               reset,
    input logic               busy_i,
    input logic [MD_OP_W-1:0] op_i
);

    a_no_muldiv_while_busy: assert property (
        @(posedge clk) disable iff (reset) !(busy_i && is_muldiv(op_i))
    ) else $error("mdu_sched: mult/div op issued while busy");

    a_no_mt_while_busy: assert property (
        @(posedge clk) disable iff (reset)
        !(busy_i && (op_i == MD_MTHI || op_i == MD_MTLO))
    ) else $error("mdu_sched: MTHI/MTLO issued while busy");

endmodule

// File: rtl/mdu_sched_md_calc.sv
// Purely combinational 64-bit multiply/divide result generator.
// Ports:
//   op_i  - MD operation (only MULT/MULTU/DIV/DIVU produce a result)
//   a_i   - rs operand (multiplicand / dividend)
//   b_i   - rt operand (multiplier / divisor)
//   res_o - {hi, lo, wr_en}; wr_en=0 for divide by zero or non-arith ops
module md_calc
    import mdu_sched_pkg::*;
(
    input  logic [MD_OP_W-1:0] op_i,
    input  logic [31:0]        a_i,
    input  logic [31:0]        b_i,
    output md_res_t            res_o
);

    logic        sgn_div_s;
    logic [63:0] prod_s;
    logic [31:0] a_mag_s;
    logic [31:0] b_mag_s;
    logic [31:0] q_mag_s;
    logic [31:0] r_mag_s;

    // Result generation. Signed division works on magnitudes so that
    // 0x80000000 / -1 needs no special case: its magnitude quotient is
    // 0x80000000 and, with equal signs, it is returned unnegated.
    always_comb begin
        res_o     = '0;
        prod_s    = 64'd0;
        sgn_div_s = (op_i == MD_DIV);
        a_mag_s   = (sgn_div_s && a_i[31]) ? (32'd0 - a_i) : a_i;
        b_mag_s   = (sgn_div_s && b_i[31]) ? (32'd0 - b_i) : b_i;
        if (b_mag_s == 32'd0) begin
            q_mag_s = 32'd0;
            r_mag_s = 32'd0;
        end else begin
            q_mag_s = a_mag_s / b_mag_s;
            r_mag_s = a_mag_s % b_mag_s;
        end
        case (op_i)
            MD_MULT: begin
                prod_s      = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
                res_o.hi    = prod_s[63:32];
                res_o.lo    = prod_s[31:0];
                res_o.wr_en = 1'b1;
            end
            MD_MULTU: begin
                prod_s      = {32'd0, a_i} * {32'd0, b_i};
                res_o.hi    = prod_s[63:32];
                res_o.lo    = prod_s[31:0];
                res_o.wr_en = 1'b1;
            end
            MD_DIV: begin
                // quotient sign = sign(a) xor sign(b); remainder follows a
                res_o.lo    = (a_i[31] ^ b_i[31]) ? (32'd0 - q_mag_s) : q_mag_s;
                res_o.hi    = a_i[31] ? (32'd0 - r_mag_s) : r_mag_s;
                res_o.wr_en = (b_i != 32'd0);
            end
            MD_DIVU: begin
                res_o.lo    = q_mag_s;
                res_o.hi    = r_mag_s;
                res_o.wr_en = (b_i != 32'd0);
            end
            default: begin
                res_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/mdu_sched.sv
// Multi-cycle multiply/divide scheduler. Accepts the MD op of the E-stage
// instruction, owns HI/LO, times MULT/DIV latency with a down-counter and
// requests a stall while a D-stage MD instruction would find it occupied.
// Ports:
//   clk, reset - clock, synchronous active-high reset
//   E_md_op    - MD op in E (MD_NONE for bubbles/non-MD instructions)
//   E_A, E_B   - forwarded rs/rt values in E
//   D_md_use   - D-stage instruction is any MD op
//   busy       - a MULT/DIV is in progress
//   md_stall   - stall request ORed into the hazard unit's stall
//   md_out     - HI when E_md_op==MD_MFHI, else LO (zero latency)
module mdu_sched
    import mdu_sched_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
)(
    input  logic               clk,
    input  logic               reset,
    input  logic [MD_OP_W-1:0] E_md_op,
    input  logic [31:0]        E_A,
    input  logic [31:0]        E_B,
    input  logic               D_md_use,
    output logic               busy,
    output logic               md_stall,
    output logic [31:0]        md_out
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic        pend_wr_q, pend_wr_d;
    logic        start_s;
    md_res_t     calc_res_s;

    md_calc u_md_calc (
        .op_i  (E_md_op),
        .a_i   (E_A),
        .b_i   (E_B),
        .res_o (calc_res_s)
    );

    mdu_sched_chk u_chk (
        .clk    (clk),
        .reset  (reset),
        .busy_i (busy),
        .op_i   (E_md_op)
    );

    assign busy     = (cnt_q != 4'd0);
    assign start_s  = is_muldiv(E_md_op) && !busy;
    // Covering the start cycle keeps a back-to-back MD op in D until
    // the cycle after busy falls.
    assign md_stall = D_md_use && (start_s || busy);
    assign md_out   = (E_md_op == MD_MFHI) ? hi_q : lo_q;

    // Next-state logic: start, count-down, commit and MTHI/MTLO writes.
    // Ops arriving while busy are ignored (the checker flags them).
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    state_d   = ST_BUSY;
                    cnt_d     = is_mult(E_md_op) ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
                    pend_hi_d = calc_res_s.hi;
                    pend_lo_d = calc_res_s.lo;
                    pend_wr_d = calc_res_s.wr_en;
                end else if (E_md_op == MD_MTHI) begin
                    hi_d = E_A;
                end else if (E_md_op == MD_MTLO) begin
                    lo_d = E_A;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_q <= 4'd1) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end else begin
                        hi_d = hi_q;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State, counter, HI/LO and pending-result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

endmodule

// File: tb/tb_mdu_sched.sv
// Self-checking bench for mdu_sched: directed scenarios followed by random
// traffic, all compared against a behavioural model of HI/LO and latency.
module tb_mdu_sched;
    import mdu_sched_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  E_md_op = 4'd0;
    logic [31:0] E_A = 32'd0;
    logic [31:0] E_B = 32'd0;
    logic        D_md_use = 1'b0;
    logic        busy;
    logic        md_stall;
    logic [31:0] md_out;

    int n_assert = 0;
    int n_fail   = 0;

    // model state
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_phi = 32'd0, m_plo = 32'd0;
    logic        m_pwr = 1'b0;
    int          m_rem = 0;

    // last sampled DUT outputs
    logic        s_busy, s_stall;
    logic [31:0] s_out;

    mdu_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .E_md_op  (E_md_op),
        .E_A      (E_A),
        .E_B      (E_B),
        .D_md_use (D_md_use),
        .busy     (busy),
        .md_stall (md_stall),
        .md_out   (md_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Architectural result of a mult/div, straight from 64-bit arithmetic.
    task automatic model_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r, p;
        logic [63:0] pu;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        m_pwr = 1'b1;
        if (op == MD_MULT) begin
            p = sa * sb; m_phi = p[63:32]; m_plo = p[31:0];
        end else if (op == MD_MULTU) begin
            pu = {32'd0, a} * {32'd0, b}; m_phi = pu[63:32]; m_plo = pu[31:0];
        end else if (b == 32'd0) begin
            m_pwr = 1'b0;
        end else if (op == MD_DIV) begin
            q = sa / sb; r = sa % sb; m_plo = q[31:0]; m_phi = r[31:0];
        end else begin
            m_plo = a / b; m_phi = a % b;
        end
    endtask

    // One clock: drive inputs at negedge, check outputs, then apply the edge to the model.
    task automatic cycle(input logic rst, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic duse);
        logic e_busy, e_start, e_stall;
        logic [31:0] e_out;
        @(negedge clk);
        reset = rst; E_md_op = op; E_A = a; E_B = b; D_md_use = duse;
        #2;
        e_busy  = (m_rem != 0);
        e_start = (op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU}) && !e_busy;
        e_stall = duse && (e_start || e_busy);
        e_out   = (op == MD_MFHI) ? m_hi : m_lo;
        s_busy = busy; s_stall = md_stall; s_out = md_out;
        chk("busy",     {31'd0, s_busy},  {31'd0, e_busy});
        chk("md_stall", {31'd0, s_stall}, {31'd0, e_stall});
        chk("md_out",   s_out, e_out);
        @(posedge clk);
        if (rst) begin
            m_hi = 32'd0; m_lo = 32'd0; m_rem = 0; m_pwr = 1'b0;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0 && m_pwr) begin m_hi = m_phi; m_lo = m_plo; end
        end else if (e_start) begin
            model_result(op, a, b);
            m_rem = (op == MD_MULT || op == MD_MULTU) ? 5 : 10;
        end else if (op == MD_MTHI) begin
            m_hi = a;
        end else if (op == MD_MTLO) begin
            m_lo = a;
        end
    endtask

    initial begin
        logic [3:0]  rop;
        logic [31:0] ra, rb;
        @(posedge clk);
        // reset state
        cycle(1'b1, MD_MFHI, 32'd0, 32'd0, 1'b1);
        chk("rst_hi", s_out, 32'd0);
        chk("rst_stall", {31'd0, s_stall}, 32'd0);
        cycle(1'b0, MD_MFLO, 32'd0, 32'd0, 1'b0);
        chk("rst_lo", s_out, 32'd0);

        // MULT -2 * 3: busy for 5 cycles, result visible at t+6
        cycle(1'b0, MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
        chk("mult_start_busy", {31'd0, s_busy}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, MD_NONE, 32'd0, 32'd0, 1'b0);
            chk("mult_busy", {31'd0, s_busy}, 32'd1);
        end
        cycle(1'b0, MD_MFHI, 32'd0, 32'd0, 1'b0);
        chk("mult_hi", s_out, 32'hFFFF_FFFF);
        chk("mult_idle", {31'd0, s_busy}, 32'd0);
        cycle(1'b0, MD_MFLO, 32'd0, 32'd0, 1'b0);
        chk("mult_lo", s_out, 32'hFFFF_FFFA);

        // DIVU 100/7 with MFLO waiting in D: 11 stall cycles
        cycle(1'b0, MD_DIVU, 32'd100, 32'd7, 1'b1);
        chk("divu_stall_t0", {31'd0, s_stall}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, MD_NONE, 32'd0, 32'd0, 1'b1);
            chk("divu_stall", {31'd0, s_stall}, 32'd1);
        end
        cycle(1'b0, MD_MFLO, 32'd0, 32'd0, 1'b0);
        chk("divu_lo", s_out, 32'd14);
        chk("divu_nostall", {31'd0, s_stall}, 32'd0);
        cycle(1'b0, MD_MFHI, 32'd0, 32'd0, 1'b0);
        chk("divu_hi", s_out, 32'd2);

        // DIV -7/2
        cycle(1'b0, MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        repeat (10) cycle(1'b0, MD_NONE, 32'd0, 32'd0, 1'b0);
        cycle(1'b0, MD_MFLO, 32'd0, 32'd0, 1'b0);
        chk("div_neg_lo", s_out, 32'hFFFF_FFFD);
        cycle(1'b0, MD_MFHI, 32'd0, 32'd0, 1'b0);
        chk("div_neg_hi", s_out, 32'hFFFF_FFFF);

        // DIV overflow case
        cycle(1'b0, MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        repeat (10) cycle(1'b0, MD_NONE, 32'd0, 32'd0, 1'b0);
        cycle(1'b0, MD_MFLO, 32'd0, 32'd0, 1'b0);
        chk("div_ovf_lo", s_out, 32'h8000_0000);
        cycle(1'b0, MD_MFHI, 32'd0, 32'd0, 1'b0);
        chk("div_ovf_hi", s_out, 32'd0);

        // MTHI then MFHI, then divide by zero leaves HI/LO alone
        cycle(1'b0, MD_MTHI, 32'h1234_5678, 32'd0, 1'b1);
        chk("mthi_nostall", {31'd0, s_stall}, 32'd0);
        cycle(1'b0, MD_MFHI, 32'd0, 32'd0, 1'b0);
        chk("mthi_read", s_out, 32'h1234_5678);
        cycle(1'b0, MD_DIVU, 32'd55, 32'd0, 1'b0);
        repeat (10) cycle(1'b0, MD_NONE, 32'd0, 32'd0, 1'b0);
        cycle(1'b0, MD_MFHI, 32'd0, 32'd0, 1'b0);
        chk("div0_hi", s_out, 32'h1234_5678);
        cycle(1'b0, MD_MFLO, 32'd0, 32'd0, 1'b0);
        chk("div0_lo", s_out, 32'h8000_0000);

        // reset in busy cycle 3 of a MULT abandons the result
        cycle(1'b0, MD_MULT, 32'd7, 32'd9, 1'b0);
        cycle(1'b0, MD_NONE, 32'd0, 32'd0, 1'b0);
        cycle(1'b0, MD_NONE, 32'd0, 32'd0, 1'b0);
        cycle(1'b1, MD_NONE, 32'd0, 32'd0, 1'b0);
        cycle(1'b0, MD_MFHI, 32'd0, 32'd0, 1'b1);
        chk("rstmid_busy", {31'd0, s_busy}, 32'd0);
        chk("rstmid_hi", s_out, 32'd0);
        chk("rstmid_stall", {31'd0, s_stall}, 32'd0);
        repeat (6) cycle(1'b0, MD_NONE, 32'd0, 32'd0, 1'b0);
        cycle(1'b0, MD_MFLO, 32'd0, 32'd0, 1'b0);
        chk("rstmid_nocommit", s_out, 32'd0);

        // non-MD instruction in D while busy: no stall
        cycle(1'b0, MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
        cycle(1'b0, MD_NONE, 32'd0, 32'd0, 1'b0);
        chk("nonmd_busy_nostall", {31'd0, s_stall}, 32'd0);
        repeat (4) cycle(1'b0, MD_NONE, 32'd0, 32'd0, 1'b0);
        cycle(1'b0, MD_MFHI, 32'd0, 32'd0, 1'b1);
        chk("duse_idle_nostall", {31'd0, s_stall}, 32'd0);
        chk("multu_hi", s_out, 32'd1);

        // random traffic; mult/div/MT only offered while idle
        for (int i = 0; i < 600; i++) begin
            if (m_rem != 0) begin
                case ($urandom_range(2, 0))
                    0:       rop = MD_NONE;
                    1:       rop = MD_MFHI;
                    default: rop = MD_MFLO;
                endcase
            end else begin
                rop = 4'($urandom_range(8, 0));
            end
            ra = ($urandom_range(3, 0) == 0) ? 32'($urandom_range(20, 0)) : $urandom;
            case ($urandom_range(5, 0))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'($urandom_range(9, 1));
                default: rb = $urandom;
            endcase
            cycle(($urandom_range(80, 0) == 0), rop, ra, rb, 1'($urandom_range(1, 0)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
